// File: rtl/gecko_pkg.sv
// gecko_pkg: shared types and address decode helper for the gecko data-side memory router.
package gecko_pkg;
  typedef struct packed {
    logic       err;
    logic [3:0] tgt;
  } gecko_mem_route_entry_t;
  typedef struct packed {
    logic       mapped;
    logic [3:0] idx;
  } gecko_mem_route_dec_t;
  // Select field is max(1, clog2(num_targets)) bits wide; any set bit above it is unmapped.
  function automatic gecko_mem_route_dec_t gecko_mem_route_decode(input logic [63:0] addr, input int shift, input int num_targets);
    gecko_mem_route_dec_t r;
    int sel_w;
    logic [63:0] f;
    sel_w = (num_targets > 2) ? $clog2(num_targets) : 1;
    f = (addr >> shift) & ((64'd1 << sel_w) - 64'd1);
    r.idx = f[3:0];
    r.mapped = (f < 64'(num_targets)) && ((addr >> (shift + sel_w)) == 64'd0);
    return r;
  endfunction
endpackage

// File: rtl/gecko_mem_route_queue.sv
// gecko_mem_route_queue: synchronous FIFO of routing entries; caller never pushes when full or pops when empty.
module gecko_mem_route_queue
  import gecko_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  gecko_mem_route_entry_t       din,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output gecko_mem_route_entry_t       head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  gecko_mem_route_entry_t mem_q [DEPTH];
  gecko_mem_route_entry_t mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = wr_q + PW'(push);
    rd_d = rd_q + PW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
    mem_q <= mem_d;
  end
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign head = mem_q[rd_q];
endmodule

// File: rtl/gecko_mem_router.sv
// gecko_mem_router: one core data port routed to NUM_TARGETS regions with in-order results.
// Optional GECKO_MEM_ROUTER_WRITE_ACK_EN: writes also queue and receive responses.
module gecko_mem_router
  import gecko_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_TARGETS     = 3,
  parameter int REGION_SHIFT    = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [ADDR_WIDTH-1:0]                req_addr,
  input  logic [DATA_WIDTH-1:0]                req_data,
  input  logic [DATA_WIDTH/8-1:0]              req_write_enable,
  output logic [NUM_TARGETS-1:0]               tgt_req_valid,
  input  logic [NUM_TARGETS-1:0]               tgt_req_ready,
  output logic [ADDR_WIDTH-1:0]                tgt_req_addr,
  output logic [DATA_WIDTH-1:0]                tgt_req_data,
  output logic [DATA_WIDTH/8-1:0]              tgt_req_write_enable,
  input  logic [NUM_TARGETS-1:0]               tgt_res_valid,
  output logic [NUM_TARGETS-1:0]               tgt_res_ready,
  input  logic [NUM_TARGETS*DATA_WIDTH-1:0]    tgt_res_data,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [DATA_WIDTH-1:0]                res_data,
  output logic                                 res_error,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 unmapped_flag
);
`ifdef GECKO_MEM_ROUTER_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif
  gecko_mem_route_dec_t dec;
  gecko_mem_route_entry_t entry, head;
  logic is_wr, needs_q, blocked, push, pop, full, empty, hv;
  logic [DATA_WIDTH-1:0] hd;
  logic unmapped_flag_q, unmapped_flag_d;
  gecko_mem_route_queue #(.DEPTH(MAX_OUTSTANDING)) u_queue (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(entry),
    .full(full), .empty(empty), .count(outstanding), .head(head)
  );
  always_comb begin
    dec = gecko_mem_route_decode(64'(req_addr), REGION_SHIFT, NUM_TARGETS);
    is_wr = |req_write_enable;
    needs_q = ACK || !is_wr;
    // A full queue blocks even with a same-cycle pop so req_ready never depends on res_ready.
    blocked = needs_q && full;
    tgt_req_valid = '0;
    tgt_res_ready = '0;
    req_ready = dec.mapped ? 1'b0 : !blocked;
    hv = 1'b0;
    hd = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (dec.mapped && dec.idx == 4'(i)) begin
        tgt_req_valid[i] = req_valid && !blocked;
        req_ready = tgt_req_ready[i] && !blocked;
      end
      if (head.tgt == 4'(i)) begin
        hv = tgt_res_valid[i];
        hd = tgt_res_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      tgt_res_ready[i] = res_ready && !empty && !head.err && head.tgt == 4'(i);
    end
    res_valid = !empty && (head.err || hv);
    res_data = head.err ? '0 : hd;
    res_error = !empty && head.err;
    push = req_valid && req_ready && needs_q;
    pop = res_valid && res_ready;
    entry = '{err: !dec.mapped, tgt: dec.idx};
    unmapped_flag_d = !ACK && (unmapped_flag_q || (req_valid && req_ready && is_wr && !dec.mapped));
  end
  always_ff @(posedge clk) begin
    if (rst) unmapped_flag_q <= 1'b0;
    else unmapped_flag_q <= unmapped_flag_d;
  end
  assign unmapped_flag = unmapped_flag_q;
  assign tgt_req_addr = req_addr;
  assign tgt_req_data = req_data;
  assign tgt_req_write_enable = req_write_enable;
endmodule

// File: tb/tb_gecko_mem_router.sv
// tb_gecko_mem_router: scenario tasks with a scoreboard of expected core results.
module tb_gecko_mem_router;
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_ready;
  logic [31:0] req_addr = 0, req_data = 0;
  logic [3:0]  req_write_enable = 0;
  logic [2:0]  tgt_req_valid, tgt_req_ready = 3'b111;
  logic [31:0] tgt_req_addr, tgt_req_data;
  logic [3:0]  tgt_req_write_enable;
  logic [2:0]  tgt_res_valid = 0, tgt_res_ready;
  logic [95:0] tgt_res_data = 0;
  logic        res_valid, res_ready = 1, res_error;
  logic [31:0] res_data;
  logic [2:0]  outstanding;
  logic        unmapped_flag;
  int checks = 0, errors = 0;
  logic [32:0] sb [$];
  gecko_mem_router dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_write_enable(req_write_enable), .tgt_req_valid(tgt_req_valid),
    .tgt_req_ready(tgt_req_ready), .tgt_req_addr(tgt_req_addr), .tgt_req_data(tgt_req_data),
    .tgt_req_write_enable(tgt_req_write_enable), .tgt_res_valid(tgt_res_valid),
    .tgt_res_ready(tgt_res_ready), .tgt_res_data(tgt_res_data), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_error(res_error),
    .outstanding(outstanding), .unmapped_flag(unmapped_flag)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  // Every core handshake must match the oldest expected {err, data}.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      logic [32:0] e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got err=%0b data=%h, expected no result", res_error, res_data);
      end else begin
        e = sb.pop_front();
        if ({res_error, res_data} !== e) begin
          errors++;
          $display("FAIL sb_result got err=%0b data=%h, expected err=%0b data=%h", res_error, res_data, e[32], e[31:0]);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain %0d results still pending, expected 0", sb.size());
    end
  endtask
  task automatic rd(input logic [31:0] a);
    req_valid = 1;
    req_addr = a;
    req_write_enable = 0;
    #1;
  endtask
  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
    checks += 4;
    if (outstanding !== 0) begin errors++; $display("FAIL reset_outstanding got %0d expected 0", outstanding); end
    if (res_valid !== 0) begin errors++; $display("FAIL reset_res_valid got %0b expected 0", res_valid); end
    if (unmapped_flag !== 0) begin errors++; $display("FAIL reset_flag got %0b expected 0", unmapped_flag); end
    if (tgt_res_ready !== 0 || tgt_req_valid !== 0) begin errors++; $display("FAIL reset_tgt got res_ready=%b req_valid=%b expected 0", tgt_res_ready, tgt_req_valid); end
  endtask
  task automatic test_mapped_read();
    rd(32'h0001_0004);
    checks += 2;
    if (tgt_req_valid !== 3'b010 || tgt_req_addr !== 32'h0001_0004) begin errors++; $display("FAIL mr_route got v=%b a=%h expected 010 00010004", tgt_req_valid, tgt_req_addr); end
    if (req_ready !== 1) begin errors++; $display("FAIL mr_ready got %0b expected 1", req_ready); end
    sb.push_back({1'b0, 32'hDEADBEEF});
    tick();
    req_valid = 0;
    #1;
    checks++;
    if (outstanding !== 1) begin errors++; $display("FAIL mr_outstanding got %0d expected 1", outstanding); end
    tgt_res_valid[1] = 1;
    tgt_res_data[63:32] = 32'hDEADBEEF;
    #1;
    checks++;
    if (tgt_res_ready !== 3'b010) begin errors++; $display("FAIL mr_tgt_res_ready got %b expected 010", tgt_res_ready); end
    tick();
    tgt_res_valid = 0;
    drain();
  endtask
  task automatic test_out_of_order();
    rd(32'h0002_0000);
    sb.push_back({1'b0, 32'h22});
    tick();
    rd(32'h0000_0000);
    sb.push_back({1'b0, 32'h11});
    tick();
    req_valid = 0;
    tgt_res_valid[0] = 1;
    tgt_res_data[31:0] = 32'h11;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (tgt_res_ready[0] !== 0 || res_valid !== 0) begin errors++; $display("FAIL ooo_stall got rdy0=%0b res_valid=%0b expected 0 0", tgt_res_ready[0], res_valid); end
      tick();
    end
    tgt_res_valid[2] = 1;
    tgt_res_data[95:64] = 32'h22;
    #1;
    checks++;
    if (tgt_res_ready !== 3'b100) begin errors++; $display("FAIL ooo_rdy2 got %b expected 100", tgt_res_ready); end
    tick();
    tgt_res_valid[2] = 0;
    #1;
    checks++;
    if (tgt_res_ready !== 3'b001) begin errors++; $display("FAIL ooo_rdy0 got %b expected 001", tgt_res_ready); end
    tick();
    tgt_res_valid = 0;
    drain();
  endtask
  task automatic test_unmapped_read();
    rd(32'h0003_0000);
    checks += 2;
    if (tgt_req_valid !== 0 || req_ready !== 1) begin errors++; $display("FAIL ur_first got v=%b rdy=%0b expected 000 1", tgt_req_valid, req_ready); end
    if (res_valid !== 0) begin errors++; $display("FAIL ur_early got res_valid=%0b expected 0", res_valid); end
    sb.push_back({1'b1, 32'h0});
    tick();
    rd(32'h0100_0000);
    checks += 2;
    if (tgt_req_valid !== 0 || req_ready !== 1) begin errors++; $display("FAIL ur_high got v=%b rdy=%0b expected 000 1", tgt_req_valid, req_ready); end
    if (res_valid !== 1 || res_error !== 1) begin errors++; $display("FAIL ur_next got v=%0b e=%0b expected 1 1", res_valid, res_error); end
    sb.push_back({1'b1, 32'h0});
    tick();
    req_valid = 0;
    drain();
  endtask
  task automatic test_queue_full();
    res_ready = 0;
    for (int i = 0; i < 5; i++) begin
      rd(32'h0000_0010 + 32'(i * 4));
      checks++;
      if (i < 4) begin
        if (req_ready !== 1) begin errors++; $display("FAIL qf_accept%0d got %0b expected 1", i, req_ready); end
        sb.push_back({1'b0, 32'hA0 + 32'(i)});
        tick();
      end else if (req_ready !== 0 || outstanding !== 4 || tgt_req_valid !== 0) begin
        errors++;
        $display("FAIL qf_full got rdy=%0b occ=%0d v=%b expected 0 4 000", req_ready, outstanding, tgt_req_valid);
      end
    end
    tgt_res_valid[0] = 1;
    tgt_res_data[31:0] = 32'hA0;
    res_ready = 1;
    #1;
    checks++;
    if (req_ready !== 0) begin errors++; $display("FAIL qf_pop_block got %0b expected 0", req_ready); end
    tick();
    for (int k = 1; k < 5; k++) begin
      tgt_res_data[31:0] = 32'hA0 + 32'(k);
      #1;
      if (k == 1) begin
        checks++;
        if (req_ready !== 1 || outstanding !== 3) begin errors++; $display("FAIL qf_after_pop got rdy=%0b occ=%0d expected 1 3", req_ready, outstanding); end
        sb.push_back({1'b0, 32'hA4});
      end
      tick();
      req_valid = 0;
    end
    tgt_res_valid = 0;
    drain();
  endtask
  task automatic test_unmapped_write();
    req_valid = 1;
    req_addr = 32'h0005_0000;
    req_data = 32'h1234_5678;
    req_write_enable = 4'hF;
    #1;
    checks++;
    if (req_ready !== 1 || tgt_req_valid !== 0) begin errors++; $display("FAIL uw_accept got rdy=%0b v=%b expected 1 000", req_ready, tgt_req_valid); end
`ifdef GECKO_MEM_ROUTER_WRITE_ACK_EN
    sb.push_back({1'b1, 32'h0});
`endif
    tick();
    req_valid = 0;
    req_write_enable = 0;
    #1;
    checks += 2;
`ifdef GECKO_MEM_ROUTER_WRITE_ACK_EN
    if (unmapped_flag !== 0) begin errors++; $display("FAIL uw_flag got %0b expected 0", unmapped_flag); end
    if (outstanding !== 1) begin errors++; $display("FAIL uw_occ got %0d expected 1", outstanding); end
`else
    if (unmapped_flag !== 1) begin errors++; $display("FAIL uw_flag got %0b expected 1", unmapped_flag); end
    if (outstanding !== 0) begin errors++; $display("FAIL uw_occ got %0d expected 0", outstanding); end
`endif
    drain();
    rd(32'h0000_0020);
    sb.push_back({1'b0, 32'h77});
    tick();
    req_valid = 0;
    tgt_res_valid[0] = 1;
    tgt_res_data[31:0] = 32'h77;
    tick();
    tgt_res_valid = 0;
    drain();
    checks++;
`ifdef GECKO_MEM_ROUTER_WRITE_ACK_EN
    if (unmapped_flag !== 0) begin errors++; $display("FAIL uw_sticky got %0b expected 0", unmapped_flag); end
`else
    if (unmapped_flag !== 1) begin errors++; $display("FAIL uw_sticky got %0b expected 1", unmapped_flag); end
`endif
    rst = 1;
    tick();
    rst = 0;
    #1;
    checks++;
    if (unmapped_flag !== 0) begin errors++; $display("FAIL uw_clear got %0b expected 0", unmapped_flag); end
  endtask
  task automatic test_mapped_write();
    req_valid = 1;
    req_addr = 32'h0002_0008;
    req_data = 32'hCAFE_0001;
    req_write_enable = 4'h3;
    #1;
    checks++;
    if (tgt_req_valid !== 3'b100 || tgt_req_data !== 32'hCAFE_0001 || tgt_req_write_enable !== 4'h3) begin
      errors++;
      $display("FAIL mw_route got v=%b d=%h m=%h expected 100 cafe0001 3", tgt_req_valid, tgt_req_data, tgt_req_write_enable);
    end
`ifdef GECKO_MEM_ROUTER_WRITE_ACK_EN
    sb.push_back({1'b0, 32'h55});
`endif
    tick();
    req_valid = 0;
    req_write_enable = 0;
    #1;
    checks++;
`ifdef GECKO_MEM_ROUTER_WRITE_ACK_EN
    if (outstanding !== 1) begin errors++; $display("FAIL mw_occ got %0d expected 1", outstanding); end
    tgt_res_valid[2] = 1;
    tgt_res_data[95:64] = 32'h55;
    tick();
    tgt_res_valid = 0;
`else
    if (outstanding !== 0) begin errors++; $display("FAIL mw_occ got %0d expected 0", outstanding); end
`endif
    drain();
  endtask
  task automatic test_reset_mid();
    rd(32'h0001_0000);
    tick();
    rd(32'h0001_0008);
    tick();
    req_valid = 0;
    #1;
    checks++;
    if (outstanding !== 2) begin errors++; $display("FAIL rm_occ got %0d expected 2", outstanding); end
    rst = 1;
    tick();
    rst = 0;
    #1;
    checks++;
    if (outstanding !== 0 || res_valid !== 0) begin errors++; $display("FAIL rm_cleared got occ=%0d v=%0b expected 0 0", outstanding, res_valid); end
    tgt_res_valid[1] = 1;
    tgt_res_data[63:32] = 32'h99;
    #1;
    checks++;
    if (tgt_res_ready !== 0 || res_valid !== 0) begin errors++; $display("FAIL rm_late got rdy=%b v=%0b expected 000 0", tgt_res_ready, res_valid); end
    tick();
    tgt_res_valid = 0;
  endtask
  initial begin
    test_reset();
    test_mapped_read();
    test_out_of_order();
    test_unmapped_read();
    test_queue_full();
    test_unmapped_write();
    test_mapped_write();
    test_reset_mid();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
